vga_capture: RTL and testbench
==============================

// Module: vga_capture
// PURPOSE
//  Sink-side VGA monitor: samples hsync/vsync/r/g/b as driven by the renderer and rebuilds pixel
//  coordinates. Checks line/frame timing and locks to it. Outputs per-pixel data plus a per-frame
//  checksum so benches and on-chip self-test can check rendered frames against golden values.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line      | H_FP 16  H_SYNC 96  H_BP 48   (H_TOTAL=sum=800)
//  V_ACTIVE 480  visible lines per frame      | V_FP 10  V_SYNC 2   V_BP 33   (V_TOTAL=sum=525)
//  SYNC_POL 0    sync asserted level (0 = active-low)
// PORTS
//  clk         in   1   single system clock; all logic on rising edge
//  clrn        in   1   asynchronous active-low reset
//  pix_en      in   1   pixel sample strobe; tie 1 when clk is the pixel clock
//  hsync       in   1   horizontal sync from renderer
//  vsync       in   1   vertical sync from renderer
//  r, g, b     in   4   colour components, each 4 bits
//  px_valid    out  1   px_* hold an active-area pixel (LOCKED only)
//  px_x        out  10  column 0..H_ACTIVE-1
//  px_y        out  10  row 0..V_ACTIVE-1
//  px_rgb      out  12  {r,g,b} of that pixel
//  frame_done  out  1   1-clk pulse: good frame ended; frame_sum updated
//  frame_sum   out  16  sum mod 2^16 of {r,g,b} over active pixels of last good frame
//  locked      out  1   FSM in LOCKED
//  timing_err  out  1   1-clk pulse on line/frame length mismatch
//  err_cnt     out  8   count of timing_err pulses, saturates at 255
// BEHAVIOUR
//  - Reset (clrn=0, async): all outputs and state 0, FSM=SEARCH.
//  - Stage 1 registers hsync/vsync/rgb/pix_en every clk. Stage 2 does counting/outputs.
//  - Fixed latency: 2 clk from input pins to px_* outputs.
//  - Edge = sampled sync goes deasserted->asserted on a pix_en cycle. Only pix_en cycles count.
//  - hcnt (11b, saturates 2047): 0 on hsync edge, else +1 per pix_en.
//  - At each hsync edge with hseen=1, line check: previous hcnt must equal H_TOTAL-1.
//  - hseen is set at the first hsync edge after entering SEARCH.
//  - vline (10b, saturates 1023): +1 on hsync edge; 0 on vsync edge (vsync wins when both coincide).
//  - Simultaneous edges: line check still performed.
//  - Frame check at vsync edge (SYNCING/LOCKED only): previous vline must equal V_TOTAL-1.
//  - Active window: hcnt in [H_SYNC+H_BP, +H_ACTIVE-1] and vline in [V_SYNC+V_BP, +V_ACTIVE-1].
//    px_x = hcnt-(H_SYNC+H_BP); px_y = vline-(V_SYNC+V_BP).
//  - px_valid=1 only if pix_en, LOCKED, and in window; px_* keep their last values otherwise.
//  - Accumulator: in SYNCING/LOCKED adds {r,g,b} for every in-window pixel, cleared at every vsync edge.
//  - FSM:
//    SEARCH : vsync edge -> SYNCING; no checks, no pulses.
//    SYNCING: any failed check -> SEARCH + timing_err.
//             Good frame check -> LOCKED + frame_done, frame_sum<=acc.
//    LOCKED : failed check -> SEARCH, timing_err, locked drops next clk, px_valid forced 0.
//             Good frame check -> frame_done, frame_sum<=acc.
//  - Lock needs two vsync edges: earliest lock one full frame after the first vsync edge.
//  - Counters advance on pix_en regardless of state.
//  - frame_sum holds between frame_done pulses. Re-entering SEARCH does not clear it.
//  - pix_en=0 cycles: no state change, px_valid=0.
// TESTING
//  1 Ideal 640x480, pix_en=1, rgb=12'h001 constant -> locked at 2nd vsync edge (+2 clk);
//    frame_done each frame; frame_sum=16'hB000 (307200 mod 65536); err_cnt=0.
//  2 rgb=px position pattern {x[3:0],y[3:0],4'h0} -> first px_valid (0,0) at hcnt=144,vline=35;
//    last pixel (639,479); exactly 307200 px_valid per frame; px_rgb matches pattern.
//  3 While LOCKED, one line of 799 samples -> timing_err pulse, err_cnt=1, locked=0.
//    No frame_done for that frame; relock one full frame after the next vsync edge.
//  4 Same timing with pix_en=1 every 2nd clk -> identical frame_sum/coordinates; px_valid only on pix_en cycles.
//  5 clrn pulsed low mid-frame -> all outputs 0 immediately (async); FSM SEARCH; relock as in 1.
//  6 vsync and hsync edges on same sample -> vline=0, line check done, lock unaffected.

Source files
------------

// File: rtl/vga_capture.sv
// Sink-side VGA monitor: rebuilds pixel coordinates from hsync/vsync, checks line/frame timing, locks and checksums frames.
// Latency: 2 clk from input pins to px_*, frame_done and timing_err (input register stage, then processing stage).
// Backpressure: none; one sample is taken on every pix_en cycle, outputs are pulses or held values.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        px_valid,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic [11:0] px_rgb,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        locked,
    output logic        timing_err,
    output logic [7:0]  err_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_LO   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_HI   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_LO   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_HI   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic        POL    = (SYNC_POL != 0);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        SYNCING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        s1_hs, s1_vs, s1_en;
    logic [11:0] s1_rgb;
    logic        hs_prev, vs_prev;
    logic [10:0] hcnt, hcnt_nxt;
    logic [9:0]  vline, vline_nxt;
    logic        hseen;
    logic [15:0] acc;
    logic        hedge, vedge, checking, line_bad, frame_bad, fail, frame_good;
    logic        in_win, pix_ok, err_d, done_d;

    // Edges only count on pix_en samples; the previous sync level is tracked on those samples only.
    assign hedge = s1_en && (s1_hs == POL) && (hs_prev != POL);
    assign vedge = s1_en && (s1_vs == POL) && (vs_prev != POL);

    // Position of the current sample: counters restart on their edge, vsync wins over hsync.
    assign hcnt_nxt  = hedge ? 11'd0 : ((hcnt == 11'h7FF) ? hcnt : hcnt + 11'd1);
    assign vline_nxt = vedge ? 10'd0 : ((hedge && vline != 10'h3FF) ? vline + 10'd1 : vline);

    // Checks compare the length of the line/frame that just ended (counter value before restart).
    assign checking   = (state_q != SEARCH);
    assign line_bad   = hedge && hseen && checking && (hcnt != H_LAST);
    assign frame_bad  = vedge && checking && (vline != V_LAST);
    assign fail       = line_bad || frame_bad;
    assign frame_good = vedge && checking && !fail;

    assign in_win = s1_en && (hcnt_nxt >= H_LO) && (hcnt_nxt <= H_HI)
                          && (vline_nxt >= V_LO) && (vline_nxt <= V_HI);
    assign pix_ok = in_win && (state_q == LOCKED) && !fail;
    assign locked = (state_q == LOCKED);

    // Input capture stage: everything is registered once before interpretation.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_en  <= 1'b0;
            s1_rgb <= 12'h000;
        end else begin
            s1_hs  <= hsync;
            s1_vs  <= vsync;
            s1_en  <= pix_en;
            s1_rgb <= {r, g, b};
        end
    end

    // Lock FSM next state and the timing_err / frame_done decisions.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            SEARCH: begin
                if (vedge) state_d = SYNCING;
            end
            SYNCING: begin
                if (fail) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                end else if (frame_good) begin
                    state_d = LOCKED;
                    done_d  = 1'b1;
                end
            end
            LOCKED: begin
                if (fail) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                end else if (frame_good) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Lock FSM state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= SEARCH;
        else       state_q <= state_d;
    end

    // Position counters and sync history advance on pix_en samples in every state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            hcnt    <= 11'd0;
            vline   <= 10'd0;
            hseen   <= 1'b0;
        end else if (s1_en) begin
            hs_prev <= s1_hs;
            vs_prev <= s1_vs;
            hcnt    <= hcnt_nxt;
            vline   <= vline_nxt;
            // A failing edge drops back to SEARCH; the next hsync edge re-arms line checks.
            if (fail)       hseen <= 1'b0;
            else if (hedge) hseen <= 1'b1;
        end
    end

    // Frame checksum: restart at each vsync edge, publish only on a good frame.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            acc       <= 16'h0000;
            frame_sum <= 16'h0000;
        end else begin
            if (vedge)                 acc <= 16'h0000;
            else if (in_win && checking) acc <= acc + {4'h0, s1_rgb};
            if (done_d) frame_sum <= acc;
        end
    end

    // Pixel and status outputs; px_* hold their last value between valid pixels.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            px_valid   <= 1'b0;
            px_x       <= 10'd0;
            px_y       <= 10'd0;
            px_rgb     <= 12'h000;
            frame_done <= 1'b0;
            timing_err <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            px_valid   <= pix_ok;
            frame_done <= done_d;
            timing_err <= err_d;
            if (pix_ok) begin
                px_x   <= 10'(hcnt_nxt - H_LO);
                px_y   <= vline_nxt - V_LO;
                px_rgb <= s1_rgb;
            end
            if (err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced 16x8 raster: renderer tasks, a sample-level reference model
// (line/frame lengths measured in samples), and a per-cycle compare of every output.
module tb_vga_capture;
    localparam int HA = 16, HFP = 2, HS = 3, HB = 4;
    localparam int VA = 8,  VFP = 1, VS = 2, VB = 3;
    localparam int HT = HA + HFP + HS + HB;   // 25
    localparam int VT = VA + VFP + VS + VB;   // 14
    localparam int HSTART = HS + HB;          // 7
    localparam int VSTART = VS + VB;          // 5

    logic        clk, clrn, pix_en, hsync, vsync;
    logic [3:0]  r, g, b;
    logic        px_valid, frame_done, locked, timing_err;
    logic [9:0]  px_x, px_y;
    logic [11:0] px_rgb;
    logic [15:0] frame_sum;
    logic [7:0]  err_cnt;

    vga_capture #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
    ) dut (
        .clk(clk), .clrn(clrn), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b),
        .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
        .frame_done(frame_done), .frame_sum(frame_sum), .locked(locked),
        .timing_err(timing_err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;
    int gap_mode = 0;
    int vld_cnt = 0;
    logic [31:0] first_px, last_px;

    // ---------------- reference model ----------------
    bit [59:0] exp_stg, exp_out;
    int m_st, m_hpos, m_vln, m_err, m_acc, m_sum, m_x, m_y;
    bit m_hseen, m_phs, m_pvs, m_vld, m_done, m_terr;
    bit [11:0] m_rgb;

    function automatic bit [59:0] pack_exp();
        return {m_vld, 10'(m_x), 10'(m_y), m_rgb, m_done, 16'(m_sum),
                (m_st == 2), m_terr, 8'(m_err)};
    endfunction

    task automatic model_reset();
        m_st = 0; m_hpos = 0; m_vln = 0; m_err = 0; m_acc = 0; m_sum = 0;
        m_x = 0; m_y = 0; m_hseen = 0; m_phs = 0; m_pvs = 0;
        m_vld = 0; m_done = 0; m_terr = 0; m_rgb = 12'h000;
        exp_stg = '0; exp_out = '0;
    endtask

    // One accepted sample: judge the line/frame that just ended by its length, then place the sample.
    task automatic model_step();
        bit he, ve, bad, good, win;
        int x, y;
        exp_out = exp_stg;
        m_vld = 0; m_done = 0; m_terr = 0;
        if (pix_en) begin
            he = !hsync && m_phs;
            ve = !vsync && m_pvs;
            m_phs = hsync; m_pvs = vsync;
            bad = 0;
            if (m_st != 0) begin
                if (he && m_hseen && (m_hpos + 1) != HT) bad = 1;
                if (ve && (m_vln + 1) != VT) bad = 1;
            end
            good = ve && (m_st != 0) && !bad;
            if (he) m_hpos = 0; else if (m_hpos < 2047) m_hpos++;
            if (ve) m_vln = 0; else if (he && m_vln < 1023) m_vln++;
            x = m_hpos - HSTART; y = m_vln - VSTART;
            win = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
            if (good) m_sum = m_acc;
            if (ve) m_acc = 0;
            else if (m_st != 0 && win) m_acc = (m_acc + int'({r, g, b})) % 65536;
            if (m_st == 2 && !bad && win) begin
                m_vld = 1; m_x = x; m_y = y; m_rgb = {r, g, b};
            end
            if (bad) begin
                m_st = 0; m_terr = 1; m_hseen = 0;
                if (m_err < 255) m_err++;
            end else begin
                if (he) m_hseen = 1;
                if (m_st == 0 && ve) m_st = 1;
                else if (good) begin m_st = 2; m_done = 1; end
            end
        end
        exp_stg = pack_exp();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge clrn);
            if (!clrn) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [59:0] act;
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                act = {px_valid, px_x, px_y, px_rgb, frame_done, frame_sum,
                       locked, timing_err, err_cnt};
                checks++;
                if (act !== exp_out) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t dut=%h model=%h", $time, act, exp_out);
                end
                if (px_valid === 1'b1) begin
                    if (vld_cnt == 0) first_px = {px_x, px_y, px_rgb};
                    last_px = {px_x, px_y, px_rgb};
                    vld_cnt++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- renderer ----------------
    task automatic drive(input logic en, input logic hs, input logic vs, input logic [11:0] c);
        pix_en = en; hsync = hs; vsync = vs; {r, g, b} = c;
        @(posedge clk); #1;
    endtask

    task automatic put(input logic hs, input logic vs, input logic [11:0] c);
        if (gap_mode == 1)
            drive(1'b0, 1'($urandom), 1'($urandom), 12'($urandom));
        else if (gap_mode == 2)
            while ($urandom_range(99) < 30) drive(1'b0, 1'($urandom), 1'($urandom), 12'($urandom));
        drive(1'b1, hs, vs, c);
    endtask

    // mode 0: rgb 001, 1: rgb FFF, 2: {x,y,0} in window / random outside, 3: random
    task automatic drive_frame(input int mode, input int nlines, input int bad_line, input int delta);
        int len, x, y;
        logic [11:0] c;
        for (int v = 0; v < nlines; v++) begin
            len = HT + ((v == bad_line) ? delta : 0);
            for (int h = 0; h < len; h++) begin
                x = h - HSTART; y = v - VSTART;
                case (mode)
                    0: c = 12'h001;
                    1: c = 12'hFFF;
                    2: if (x >= 0 && x < HA && y >= 0 && y < VA) c = {x[3:0], y[3:0], 4'h0};
                       else c = 12'($urandom);
                    default: c = 12'($urandom);
                endcase
                put((h < HS) ? 1'b0 : 1'b1, (v < VS) ? 1'b0 : 1'b1, c);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b1, 1'b1, 12'h000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sel, d;
        clrn = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; r = 4'h0; g = 4'h0; b = 4'h0;
        #3 clrn = 1'b0;
        cmp_on = 1;
        @(posedge clk); #1;
        chk("reset_outputs", 64'({px_valid, px_x, px_y, px_rgb, frame_done, frame_sum,
                                  locked, timing_err, err_cnt}), 64'h0);
        @(posedge clk); #1;
        clrn = 1'b1;

        // ideal timing: lock at the second vsync edge, constant-colour checksums
        idle(5);
        drive_frame(0, VT, -1, 0);
        chk("syncing_not_locked", 64'(locked), 64'd0);
        drive_frame(1, VT, -1, 0);
        chk("locked_2nd_vsync", 64'(locked), 64'd1);
        chk("sum_rgb001", 64'(frame_sum), 64'h0080);
        chk("no_errors", 64'(err_cnt), 64'd0);
        vld_cnt = 0;
        drive_frame(2, VT, -1, 0);
        chk("sum_rgbFFF_wraps", 64'(frame_sum), 64'hFF80);
        chk("pixels_per_frame", 64'(vld_cnt), 64'd128);
        chk("first_pixel", 64'(first_px), 64'({10'd0, 10'd0, 12'h000}));
        chk("last_pixel", 64'(last_px), 64'({10'd15, 10'd7, 12'hF70}));
        drive_frame(2, VT, -1, 0);
        chk("sum_pattern", 64'(frame_sum), 64'hDC00);

        // one short line while locked
        drive_frame(3, VT, 5, -1);
        chk("short_line_err_cnt", 64'(err_cnt), 64'd1);
        chk("short_line_unlock", 64'(locked), 64'd0);
        drive_frame(3, VT, -1, 0);
        chk("relock_pending", 64'(locked), 64'd0);
        drive_frame(3, VT, -1, 0);
        chk("relocked", 64'(locked), 64'd1);

        // pix_en on every second clock
        gap_mode = 1;
        vld_cnt = 0;
        drive_frame(2, VT, -1, 0);
        chk("gapped_pixels", 64'(vld_cnt), 64'd128);
        drive_frame(2, VT, -1, 0);
        chk("gapped_sum", 64'(frame_sum), 64'hDC00);

        // randomized frames with occasional line/frame length faults
        for (int f = 0; f < 16; f++) begin
            gap_mode = $urandom_range(0, 2);
            sel = $urandom_range(0, 7);
            d = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) d = -d;
            case (sel)
                0: drive_frame(3, VT, $urandom_range(0, VT - 1), d);
                1: drive_frame(3, VT + (d > 0 ? 1 : -1), -1, 0);
                default: drive_frame(3, VT, -1, 0);
            endcase
        end

        // mid-frame asynchronous reset, then relock
        gap_mode = 0;
        for (int f = 0; f < 3; f++) drive_frame(3, VT, -1, 0);
        chk("locked_before_reset", 64'(locked), 64'd1);
        drive_frame(3, 6, -1, 0);
        clrn = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({px_valid, px_x, px_y, px_rgb, frame_done, frame_sum,
                                        locked, timing_err, err_cnt}), 64'h0);
        idle(3);
        clrn = 1'b1;
        idle(5);
        drive_frame(0, VT, -1, 0);
        chk("post_reset_syncing", 64'(locked), 64'd0);
        drive_frame(0, VT, -1, 0);
        chk("post_reset_locked", 64'(locked), 64'd1);
        chk("post_reset_sum", 64'(frame_sum), 64'h0080);

        // repeated short frames drive err_cnt into saturation
        for (int i = 0; i < 600; i++)
            for (int h = 0; h < 10; h++)
                put((h < 3) ? 1'b0 : 1'b1, (h < 3) ? 1'b0 : 1'b1, 12'h000);
        chk("err_cnt_saturates", 64'(err_cnt), 64'd255);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
